ahb_bus_arbiter: RTL

- Round-robin arbiter that shares the single AHB slave port of the AHB-to-APB bridge between NUM_MASTERS requesting masters.
- Tracks burst progress from the granted master's Htrans/Hburst and the bridge's Hreadyout/Hresp.
- Re-arbitrates only at legal handover points: end of a fixed-length burst, IDLE, end of an INCR burst, or an ERROR response.
- Sits between the master-side Htrans/Haddr/Hwdata multiplexers, which it steers via Hmaster, and the bridge slave.

---
 rtl/ahb_bus_arbiter_if.sv | 27 ++
 rtl/ahb_bus_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/ahb_bus_arbiter_if.sv
// Arbiter-side AHB signal bundle: muxed owner transfer controls and bridge response in, grant/owner out.
// The master modport is the arbiter's view; slave is the view of the logic it steers.
interface ahb_bus_arbiter_if #(
   parameter int NUM_MASTERS = 4,
   parameter int MW          = 2
);
   logic [NUM_MASTERS-1:0] Hbusreq;
   logic [NUM_MASTERS-1:0] Hlock;
   logic [1:0]             Htrans;
   logic [2:0]             Hburst;
   logic                   Hreadyout;
   logic [1:0]             Hresp;
   logic [NUM_MASTERS-1:0] Hgrant;
   logic [MW-1:0]          Hmaster;
   logic                   Hmastlock;
   logic [4:0]             Hbeats_left;

   modport master (
      input  Hbusreq, Hlock, Htrans, Hburst, Hreadyout, Hresp,
      output Hgrant, Hmaster, Hmastlock, Hbeats_left
   );

   modport slave (
      output Hbusreq, Hlock, Htrans, Hburst, Hreadyout, Hresp,
      input  Hgrant, Hmaster, Hmastlock, Hbeats_left
   );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter handing the bridge slave port over only at burst/IDLE/ERROR boundaries.
// Grant changes on the handover edge itself; Hreadyout low freezes every register.
module ahb_bus_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int MW          = 2
) (
   input logic             Hclk,
   input logic             Hreset,
   ahb_bus_arbiter_if.master bus
);
   localparam logic [1:0] ARB       = 2'd0;
   localparam logic [1:0] BURST     = 2'd1;
   localparam logic [1:0] INCR_OPEN = 2'd2;

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [1:0] T_SEQ    = 2'b11;
   localparam logic [2:0] B_SINGLE = 3'b000;
   localparam logic [2:0] B_INCR   = 3'b001;
   localparam logic [1:0] R_ERROR  = 2'b01;

   localparam logic [NUM_MASTERS-1:0] GRANT0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

   logic [1:0]    state, state_nxt;
   logic [4:0]    beats_nxt, burst_len;
   logic          is_idle, is_nonseq, is_seq, is_err;
   logic          incr_exit, last_seq, handover, found;
   logic [MW-1:0] rr_next;
   logic [MW:0]   cand;

   assign is_idle   = (bus.Htrans == T_IDLE);
   assign is_nonseq = (bus.Htrans == T_NONSEQ);
   assign is_seq    = (bus.Htrans == T_SEQ);
   assign is_err    = (bus.Hresp == R_ERROR);

   always_comb begin
      case (bus.Hburst)
         3'b010, 3'b011: burst_len = 5'd4;
         3'b100, 3'b101: burst_len = 5'd8;
         3'b110, 3'b111: burst_len = 5'd16;
         default:        burst_len = 5'd1;
      endcase
   end

   // An open INCR burst ends when its owner starts a new transfer after dropping its request.
   assign incr_exit = (state == INCR_OPEN) && is_nonseq && !bus.Hbusreq[bus.Hmaster];
   assign last_seq  = (state == BURST) && is_seq && (bus.Hbeats_left == 5'd1);
   assign handover  = bus.Hreadyout &&
                      (is_err || is_idle || last_seq || incr_exit ||
                       ((state != BURST) && is_nonseq && (bus.Hburst == B_SINGLE)));

   always_comb begin
      state_nxt = state;
      beats_nxt = bus.Hbeats_left;
      if (is_err || is_idle) begin
         state_nxt = ARB;
         beats_nxt = 5'd0;
      end else if (state == BURST) begin
         if (is_seq) begin
            if (bus.Hbeats_left == 5'd1) begin
               state_nxt = ARB;
               beats_nxt = 5'd0;
            end else begin
               beats_nxt = bus.Hbeats_left - 5'd1;
            end
         end
      end else if (is_nonseq) begin
         beats_nxt = 5'd0;
         if (incr_exit) begin
            state_nxt = ARB;
         end else if (bus.Hburst == B_INCR) begin
            state_nxt = INCR_OPEN;
         end else if (burst_len > 5'd1) begin
            state_nxt = BURST;
            beats_nxt = burst_len - 5'd1;
         end else begin
            state_nxt = ARB;
         end
      end
   end

   // Search starts one past the owner, so the owner itself is the last candidate; no request parks.
   always_comb begin
      rr_next = bus.Hmaster;
      found   = 1'b0;
      cand    = '0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         cand = {1'b0, bus.Hmaster} + (MW+1)'(i);
         if (cand >= (MW+1)'(NUM_MASTERS)) cand = cand - (MW+1)'(NUM_MASTERS);
         if (!found && bus.Hbusreq[cand[MW-1:0]]) begin
            rr_next = cand[MW-1:0];
            found   = 1'b1;
         end
      end
   end

   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         state           <= ARB;
         bus.Hbeats_left <= 5'd0;
         bus.Hgrant      <= GRANT0;
         bus.Hmaster     <= '0;
         bus.Hmastlock   <= 1'b0;
      end else if (bus.Hreadyout) begin
         state           <= state_nxt;
         bus.Hbeats_left <= beats_nxt;
         bus.Hmastlock   <= bus.Hlock[bus.Hmaster];
         if (handover && !bus.Hlock[bus.Hmaster]) begin
            bus.Hmaster <= rr_next;
            bus.Hgrant  <= GRANT0 << rr_next;
         end
      end
   end
endmodule
